// File: rtl/dtw_sample_feeder.sv
// dtw_sample_feeder: buffers one query squiggle from a valid/ready stream, then
// clears the DTW core and streams query/reference sample pairs into it in
// lockstep, reading the reference from a synchronous memory. When the core
// signals done, its minval/position are captured and offered on a valid/ready
// result port.
module dtw_sample_feeder #(
    parameter int width    = 16,
    parameter int SQG_SIZE = 256,
    parameter int RADDR_W  = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [31:0]        ref_len_i,
    input  logic [width-1:0]   sq_data_i,
    input  logic               sq_valid_i,
    output logic               sq_ready_o,
    output logic [RADDR_W-1:0] ref_addr_o,
    input  logic [width-1:0]   ref_data_i,
    output logic               core_rst_o,
    output logic               core_running_o,
    output logic [width-1:0]   core_squiggle_o,
    output logic [width-1:0]   core_rword_o,
    output logic [31:0]        core_ref_len_o,
    input  logic [width-1:0]   core_minval_i,
    input  logic [31:0]        core_position_i,
    input  logic               core_done_i,
    output logic [width-1:0]   res_minval_o,
    output logic [31:0]        res_position_o,
    output logic               res_empty_o,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic               busy_o
);

    localparam int IDX_W = $clog2(SQG_SIZE);

    typedef enum logic [2:0] {
        LOAD,
        ARMED,
        CLR,
        RUN,
        RESULT
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   wcnt_q;
    logic [IDX_W-1:0]   sidx_q;
    logic               sq_more_q;
    logic               run_first_q;
    logic [31:0]        rcnt_q;
    logic [31:0]        rcnt_d;
    logic [31:0]        addr_q;
    logic [31:0]        addr_d;
    logic [31:0]        core_ref_len_q;
    logic               sq_ready_q;
    logic               core_rst_q;
    logic               core_running_q;
    logic [width-1:0]   core_squiggle_q;
    logic [width-1:0]   res_minval_q;
    logic [31:0]        res_position_q;
    logic               res_empty_q;
    logic               res_valid_q;
    logic               sq_accept;

    logic [width-1:0]   sample_mem [SQG_SIZE];

    assign sq_accept = sq_valid_i & sq_ready_q;

    // Query buffer: written only while loading; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (sq_accept) begin
            sample_mem[wcnt_q] <= sq_data_i;
        end
    end

    // Saturating run counter and reference address; both stop at the latched length.
    always_comb begin
        rcnt_d = rcnt_q;
        addr_d = addr_q;
        if (rcnt_q < core_ref_len_q) begin
            rcnt_d = rcnt_q + 32'd1;
        end
        if (addr_q < core_ref_len_q) begin
            addr_d = addr_q + 32'd1;
        end
    end

    // Sequencer FSM: load buffer, wait for start, clear core, stream, report result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= LOAD;
            wcnt_q          <= '0;
            sidx_q          <= '0;
            sq_more_q       <= 1'b0;
            run_first_q     <= 1'b0;
            rcnt_q          <= '0;
            addr_q          <= '0;
            core_ref_len_q  <= '0;
            sq_ready_q      <= 1'b1;
            core_rst_q      <= 1'b1;
            core_running_q  <= 1'b0;
            core_squiggle_q <= '0;
            res_minval_q    <= '0;
            res_position_q  <= '0;
            res_empty_q     <= 1'b0;
            res_valid_q     <= 1'b0;
        end else begin
            core_rst_q <= 1'b0;
            case (state_q)
                LOAD: begin
                    if (sq_accept) begin
                        if (wcnt_q == IDX_W'(SQG_SIZE - 1)) begin
                            wcnt_q     <= '0;
                            sq_ready_q <= 1'b0;
                            state_q    <= ARMED;
                        end else begin
                            wcnt_q <= wcnt_q + 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (start_i) begin
                        core_ref_len_q <= ref_len_i;
                        if (ref_len_i == 32'd0) begin
                            res_minval_q   <= '1;
                            res_position_q <= '0;
                            res_empty_q    <= 1'b1;
                            res_valid_q    <= 1'b1;
                            state_q        <= RESULT;
                        end else begin
                            core_rst_q <= 1'b1;
                            rcnt_q     <= '0;
                            addr_q     <= '0;
                            state_q    <= CLR;
                        end
                    end
                end
                CLR: begin
                    // Preload sample 0 so it lines up with ref_data for address 0.
                    core_running_q  <= 1'b1;
                    rcnt_q          <= '0;
                    addr_q          <= 32'd1;
                    core_squiggle_q <= sample_mem[0];
                    sidx_q          <= IDX_W'(1);
                    sq_more_q       <= 1'b1;
                    run_first_q     <= 1'b1;
                    state_q         <= RUN;
                end
                RUN: begin
                    run_first_q <= 1'b0;
                    rcnt_q      <= rcnt_d;
                    addr_q      <= addr_d;
                    if (sq_more_q) begin
                        core_squiggle_q <= sample_mem[sidx_q];
                        sidx_q          <= sidx_q + 1'b1;
                        if (sidx_q == IDX_W'(SQG_SIZE - 1)) begin
                            sq_more_q <= 1'b0;
                        end
                    end else begin
                        core_squiggle_q <= '0;
                    end
                    // A done seen in the first run cycle is left over from before the clear.
                    if (core_done_i && !run_first_q) begin
                        res_minval_q    <= core_minval_i;
                        res_position_q  <= core_position_i;
                        res_empty_q     <= 1'b0;
                        res_valid_q     <= 1'b1;
                        core_running_q  <= 1'b0;
                        core_squiggle_q <= '0;
                        state_q         <= RESULT;
                    end
                end
                RESULT: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        sq_ready_q  <= 1'b1;
                        state_q     <= LOAD;
                    end
                end
                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

    // Reference word mux: memory data within the reference, all-ones padding beyond it.
    always_comb begin
        core_rword_o = '0;
        if (core_running_q) begin
            if (rcnt_q < core_ref_len_q) begin
                core_rword_o = ref_data_i;
            end else begin
                core_rword_o = '1;
            end
        end
    end

    assign sq_ready_o      = sq_ready_q;
    assign ref_addr_o      = RADDR_W'(addr_q);
    assign core_rst_o      = core_rst_q;
    assign core_running_o  = core_running_q;
    assign core_squiggle_o = core_squiggle_q;
    assign core_ref_len_o  = core_ref_len_q;
    assign res_minval_o    = res_minval_q;
    assign res_position_o  = res_position_q;
    assign res_empty_o     = res_empty_q;
    assign res_valid_o     = res_valid_q;
    assign busy_o          = (state_q != LOAD);

endmodule

// File: doc/dtw_sample_feeder.md
Name: dtw_sample_feeder

Overview:
Upstream sequencer for the DTW core datapath. It collects one query squiggle of SQG_SIZE samples from a valid/ready stream into an internal buffer. It then clears the core and streams query and reference samples to it in lockstep, reading the reference from an external synchronous memory. When the core reports done, it captures the core's minval/position and presents them as a result on a valid/ready handshake.

Parameters:
width, 16, sample and score bit width
SQG_SIZE, 256, query samples per run (power of two, ≥2)
RADDR_W, 32, reference memory address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  begin run when buffer full (level-sampled)
ref_len  in  32  reference length in samples; sampled on the start accept cycle
sq_data  in  width  query sample
sq_valid  in  1  query sample valid
sq_ready  out  1  feeder accepts query sample
ref_addr  out  RADDR_W  reference memory read address
ref_data  in  width  reference read data, valid 1 cycle after ref_addr
core_rst  out  1  synchronous clear pulse to core
core_running  out  1  core run enable
core_squiggle  out  width  to core Input_squiggle
core_rword  out  width  to core Rword
core_ref_len  out  32  to core ref_len (latched copy)
core_minval  in  width  from core
core_position  in  32  from core
core_done  in  1  from core
res_minval  out  width  captured minimum
res_position  out  32  captured position
res_empty  out  1  run skipped because ref_len was 0
res_valid  out  1  result valid
res_ready  in  1  result consumer ready
busy  out  1  state is not LOAD

Behaviour:
- Reset (asynchronous): state=LOAD, sq_ready=1, all counters 0, core_rst=1, core_running=0, core_squiggle=0, core_rword=0, ref_addr=0, core_ref_len=0, res_*=0, res_valid=0, busy=0. Buffer contents are don't-care.
- States: LOAD, ARMED, CLR, RUN, RESULT.
- LOAD:
  - sq_ready=1.
  - Each cycle with sq_valid&sq_ready writes buf[wcnt] and increments wcnt.
  - On the SQG_SIZE-th accept: wcnt wraps to 0 and the state goes to ARMED; sq_ready drops in the following cycle.
- ARMED:
  - sq_ready=0.
  - When start=1: latch ref_len into core_ref_len.
  - If ref_len==0: go to RESULT with res_minval=all-ones, res_position=0, res_empty=1.
  - Otherwise go to CLR.
- CLR (exactly 1 cycle):
  - core_rst=1, core_running=0, ref_addr=0, rcnt=0.
  - Go to RUN.
- RUN:
  - core_rst=0, core_running=1.
  - In RUN cycle t (t=0,1,…), core_squiggle=buf[t] for t<SQG_SIZE, else 0.
  - core_rword=ref_data for t<core_ref_len, else all-ones (padding).
  - The registered outputs are aligned so the sample pair for index t appears on the core ports in the same cycle.
  - ref_addr=t+1 during RUN cycle t. It saturates (holds) once t+1≥core_ref_len.
  - Exit: when core_done=1 is sampled and t≥1, capture core_minval/core_position, set res_empty=0, and go to RESULT. core_running=0 from the next cycle.
  - core_done at t=0 is ignored; it is stale from before the clear.
- RESULT:
  - res_valid=1 and res_* are held stable.
  - On res_valid&res_ready: res_valid=0, go to LOAD, sq_ready=1 the next cycle.
  - res_valid must not drop without a handshake.
- start outside ARMED is ignored. sq_valid outside LOAD is not accepted (sq_ready=0).
- The buffer is not rewritten until the next LOAD, so the same query can be re-run only by reloading it (no replay).
- Reset mid-RUN: immediate return to LOAD; core_rst=1 is asserted while rst is high.
- Counters: wcnt and the buffer index are $clog2(SQG_SIZE) bits. rcnt is 32 bits and saturates at core_ref_len.

Test Plan:
- Load samples 1..SQG_SIZE, ref_len=4, start, ref memory = {5,6,7,8} → one core_rst pulse; then core_squiggle 1,2,3,… with core_rword 5,6,7,8,FFFF,… per cycle; ref_addr sequence 0,1,2,3,4,4,….
- Stub core_done high at RUN t=0 then low until t=300; drive core_minval=0x0042, core_position=4 → t=0 done ignored; res_valid with 0x0042/4, res_empty=0.
- Hold res_ready=0 for 10 cycles → res_valid and res_* stable, sq_ready=0; then res_ready=1 → LOAD next cycle.
- ref_len=0 at start → no core_running pulse; res_valid with minval=FFFF, position=0, res_empty=1.
- Gapped sq_valid (every other cycle) with start held high early → no RUN until the 256th accept; exactly 256 buffer writes.
- Assert rst for 1 cycle mid-RUN → all outputs at reset values immediately; next load/run completes normally.
